// File: rtl/hit_map_assembler.sv
// Rebuilds a per-event strip hit map from a descending stream of hit addresses and
// presents it with a valid/ready handshake, a saturating hit count and protocol-error flags.

module hit_map_bit (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_bit
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        o_bit <= 1'b0;
        else if (i_clr) o_bit <= 1'b0;
        else if (i_set) o_bit <= 1'b1;
    end
endmodule

module hit_map_assembler #(
    parameter int NSTRIP      = 128,
    parameter int POS_W       = 7,
    parameter bit ORDER_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_valid_i,
    output logic              hit_ready_o,
    input  logic [POS_W-1:0]  hit_pos_i,
    input  logic              hit_last_i,
    input  logic              no_hits_i,
    output logic [NSTRIP-1:0] map_o,
    output logic              map_valid_o,
    input  logic              map_ready_i,
    output logic [7:0]        hit_count_o,
    output logic              order_err_o,
    output logic              dup_err_o
);
    typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_release;
    logic               w_hit;
    logic [NSTRIP-1:0]  w_dec;
    logic [NSTRIP-1:0]  w_map;
    logic [7:0]         r_count;
    logic [POS_W-1:0]   r_prev_pos;
    logic               r_first;
    logic               r_order_err;
    logic               r_dup_err;

    assign hit_ready_o = (r_state == COLLECT);
    assign map_valid_o = (r_state == PRESENT);
    assign w_accept    = hit_valid_i && hit_ready_o;
    assign w_release   = map_valid_o && map_ready_i;
    assign w_hit       = w_accept && !no_hits_i;
    assign w_dec       = {{(NSTRIP-1){1'b0}}, 1'b1} << hit_pos_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= COLLECT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_accept && hit_last_i) w_state_nxt = PRESENT;
            PRESENT: if (w_release)              w_state_nxt = COLLECT;
            default:                             w_state_nxt = COLLECT;
        endcase
    end

    // One storage cell per strip; the handshake clears the whole map in one edge.
    genvar g;
    generate
        for (g = 0; g < NSTRIP; g++) begin : g_bit
            hit_map_bit u_bit (
                .clk   (clk),
                .rst   (rst),
                .i_set (w_hit && w_dec[g]),
                .i_clr (w_release),
                .o_bit (w_map[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 8'd0;
            r_prev_pos  <= '0;
            r_first     <= 1'b1;
            r_order_err <= 1'b0;
            r_dup_err   <= 1'b0;
        end else if (w_release) begin
            r_count     <= 8'd0;
            r_prev_pos  <= '0;
            r_first     <= 1'b1;
            r_order_err <= 1'b0;
            r_dup_err   <= 1'b0;
        end else if (w_accept) begin
            if (!no_hits_i) begin
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                r_prev_pos <= hit_pos_i;
                r_first    <= 1'b0;
                if (!r_first && hit_pos_i == r_prev_pos)               r_dup_err   <= 1'b1;
                if (!r_first && ORDER_CHECK && hit_pos_i > r_prev_pos) r_order_err <= 1'b1;
            end else if (!r_first) begin
                // An empty-event marker is only legal as the first word of an event.
                r_order_err <= 1'b1;
            end
        end
    end

    assign map_o       = w_map;
    assign hit_count_o = r_count;
    assign order_err_o = r_order_err;
    assign dup_err_o   = r_dup_err;
endmodule

// File: tb/tb_hit_map_assembler.sv
// Bench for hit_map_assembler: two instances (order check on/off) share stimulus and are
// compared against an event-level model of the expected map, count and error flags.

module tb_hit_map_assembler;
    logic         clk = 1'b0;
    logic         rst;
    logic         hit_valid, hit_last, no_hits, map_ready;
    logic [6:0]   hit_pos;
    logic         rdy1, rdy0, mv1, mv0, oe1, oe0, de1, de0;
    logic [127:0] map1, map0;
    logic [7:0]   cnt1, cnt0;
    logic [138:0] obs1, obs0, e1, e0;
    int           total = 0;
    int           bad   = 0;
    int           w_pos[$];
    bit           w_nh[$];

    always #5 clk = ~clk;

    hit_map_assembler #(.NSTRIP(128), .POS_W(7), .ORDER_CHECK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .hit_valid_i(hit_valid), .hit_ready_o(rdy1), .hit_pos_i(hit_pos),
        .hit_last_i(hit_last), .no_hits_i(no_hits), .map_o(map1), .map_valid_o(mv1),
        .map_ready_i(map_ready), .hit_count_o(cnt1), .order_err_o(oe1), .dup_err_o(de1));

    hit_map_assembler #(.NSTRIP(128), .POS_W(7), .ORDER_CHECK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .hit_valid_i(hit_valid), .hit_ready_o(rdy0), .hit_pos_i(hit_pos),
        .hit_last_i(hit_last), .no_hits_i(no_hits), .map_o(map0), .map_valid_o(mv0),
        .map_ready_i(map_ready), .hit_count_o(cnt0), .order_err_o(oe0), .dup_err_o(de0));

    assign obs1 = {mv1, oe1, de1, cnt1, map1};
    assign obs0 = {mv0, oe0, de0, cnt0, map0};

    // Expected presentation of the whole event: set of hit strips, number of hits,
    // and whether any hit repeated / rose above the last hit or a marker came after a hit.
    function automatic logic [138:0] model(input bit oc);
        logic [127:0] m = '0;
        int n = 0, last_hit = -1;
        bit oe = 0, de = 0;
        foreach (w_pos[i]) begin
            if (w_nh[i]) begin
                if (last_hit >= 0) oe = 1;
            end else begin
                m[w_pos[i]] = 1'b1;
                n++;
                if (last_hit >= 0 && w_pos[i] == last_hit) de = 1;
                if (last_hit >= 0 && oc && w_pos[i] > last_hit) oe = 1;
                last_hit = w_pos[i];
            end
        end
        return {1'b1, oe, de, 8'((n > 255) ? 255 : n), m};
    endfunction

    task automatic set_exp();
        e1 = model(1'b1);
        e0 = model(1'b0);
    endtask

    task automatic add(input int p, input bit nh);
        w_pos.push_back(p);
        w_nh.push_back(nh);
    endtask

    // Called at a negedge; returns at the negedge after the last word's accepting edge.
    task automatic drive_event(input bit gaps);
        for (int i = 0; i < w_pos.size(); i++) begin
            if (gaps && $urandom_range(0, 4) == 0) begin
                hit_valid = 1'b0; hit_pos = 7'($urandom); no_hits = 1'($urandom); hit_last = 1'($urandom);
                @(negedge clk);
            end
            hit_valid = 1'b1; hit_pos = 7'(w_pos[i]); no_hits = w_nh[i];
            hit_last  = (i == w_pos.size() - 1);
            @(negedge clk);
        end
        hit_valid = 1'b0; hit_last = 1'b0; no_hits = 1'b0;
    endtask

    task automatic release_map();
        map_ready = 1'b1; hit_valid = 1'b1; hit_pos = 7'($urandom); hit_last = 1'b1;
        @(negedge clk);
        map_ready = 1'b0; hit_valid = 1'b0; hit_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hit_valid = 0; hit_last = 0; no_hits = 0; map_ready = 0; hit_pos = '0;
        repeat (2) @(negedge clk);
        total++; if (obs1 !== 139'd0 || obs0 !== 139'd0 || rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL reset_state got=%h/%h rdy=%b%b exp=0 rdy=11", obs1, obs0, rdy1, rdy0); end
        rst = 1'b0;
        @(negedge clk);
        hit_valid = 1'b1; hit_pos = 7'd90; hit_last = 1'b0;
        @(negedge clk);
        hit_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (obs1 !== 139'd0 || obs0 !== 139'd0 || rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL reset_midevent got=%h/%h rdy=%b%b exp=0 rdy=11", obs1, obs0, rdy1, rdy0); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (mv1 !== 1'b0 || mv0 !== 1'b0) begin
            bad++; $display("FAIL reset_no_present got=%b%b exp=00", mv1, mv0); end
        w_pos.delete(); w_nh.delete();
        add(5, 0);
        set_exp(); drive_event(0);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL reset_next_event got=%h exp=%h", obs1, e1); end
        release_map();
    endtask

    task automatic test_ordered();
        w_pos.delete(); w_nh.delete();
        add(127, 0); add(64, 0); add(3, 0);
        set_exp(); drive_event(0);
        total++; if (obs1 !== e1 || rdy1 !== 1'b0) begin
            bad++; $display("FAIL ordered_oc1 got=%h rdy=%b exp=%h rdy=0", obs1, rdy1, e1); end
        total++; if (obs0 !== e0) begin
            bad++; $display("FAIL ordered_oc0 got=%h exp=%h", obs0, e0); end
        release_map();
    endtask

    task automatic test_empty();
        w_pos.delete(); w_nh.delete();
        add(77, 1);
        set_exp(); drive_event(0);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL empty_event got=%h/%h exp=%h", obs1, obs0, e1); end
        release_map();
    endtask

    task automatic test_errors();
        w_pos.delete(); w_nh.delete();
        add(10, 0); add(10, 0); add(20, 0);
        set_exp(); drive_event(0);
        total++; if (obs1 !== e1) begin
            bad++; $display("FAIL errors_oc1 got=%h exp=%h", obs1, e1); end
        total++; if (obs0 !== e0) begin
            bad++; $display("FAIL errors_oc0 got=%h exp=%h", obs0, e0); end
        release_map();
        w_pos.delete(); w_nh.delete();
        add(50, 0); add(40, 1); add(30, 0);
        set_exp(); drive_event(1);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL errors_midmarker got=%h/%h exp=%h/%h", obs1, obs0, e1, e0); end
        release_map();
    endtask

    task automatic test_backpressure();
        w_pos.delete(); w_nh.delete();
        add(100, 0); add(55, 0); add(54, 0); add(1, 0);
        set_exp(); drive_event(1);
        for (int c = 0; c < 5; c++) begin
            total++; if (obs1 !== e1 || obs0 !== e0 || rdy1 !== 1'b0 || rdy0 !== 1'b0) begin
                bad++; $display("FAIL backpressure_hold c=%0d got=%h rdy=%b exp=%h rdy=0", c, obs1, rdy1, e1); end
            hit_valid = 1'b1; hit_pos = 7'($urandom); no_hits = 1'($urandom); hit_last = 1'($urandom);
            map_ready = 1'b0;
            @(negedge clk);
        end
        release_map();
        total++; if (obs1 !== 139'd0 || obs0 !== 139'd0 || rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL backpressure_clear got=%h rdy=%b exp=0 rdy=1", obs1, rdy1); end
        w_pos.delete(); w_nh.delete();
        add(126, 0); add(2, 0);
        set_exp(); drive_event(0);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL backpressure_next got=%h exp=%h", obs1, e1); end
        release_map();
    endtask

    task automatic test_full();
        w_pos.delete(); w_nh.delete();
        for (int p = 127; p >= 0; p--) add(p, 0);
        set_exp(); drive_event(1);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL full_map got=%h exp=%h", obs1, e1); end
        release_map();
        w_pos.delete(); w_nh.delete();
        for (int k = 0; k < 300; k++) add(int'($urandom_range(0, 127)), 0);
        set_exp(); drive_event(1);
        total++; if (obs1 !== e1 || obs0 !== e0) begin
            bad++; $display("FAIL saturate got=%h/%h exp=%h/%h", obs1, obs0, e1, e0); end
        release_map();
    endtask

    task automatic test_random();
        for (int ev = 0; ev < 10; ev++) begin
            int p;
            w_pos.delete(); w_nh.delete();
            if (ev % 2 == 0) begin
                p = 127 - int'($urandom_range(0, 5));
                while (p >= 0) begin
                    add(p, 0);
                    p -= int'($urandom_range(1, 15));
                end
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 20)); k++)
                    add(int'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0));
            end
            set_exp(); drive_event(1);
            total++; if (obs1 !== e1 || obs0 !== e0) begin
                bad++; $display("FAIL random ev=%0d got=%h/%h exp=%h/%h", ev, obs1, obs0, e1, e0); end
            release_map();
        end
    endtask

    task automatic test_back_to_back();
        for (int ev = 0; ev < 4; ev++) begin
            w_pos.delete(); w_nh.delete();
            add(120 - ev, 0); add(60 + ev, 0); add(ev, 0);
            set_exp(); drive_event(0);
            total++; if (obs1 !== e1 || obs0 !== e0) begin
                bad++; $display("FAIL b2b ev=%0d got=%h exp=%h", ev, obs1, e1); end
            release_map();
            total++; if (rdy1 !== 1'b1 || mv1 !== 1'b0 || rdy0 !== 1'b1) begin
                bad++; $display("FAIL b2b_bubble ev=%0d rdy=%b%b mv=%b exp rdy=11 mv=0", ev, rdy1, rdy0, mv1); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ordered();
        test_empty();
        test_errors();
        test_backpressure();
        test_full();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
